raster_issuer: RTL and testbench

//   Source side of the addressed-pixel stream feeding the render pipeline ahead of the line aligner.

---
 rtl/raster_issuer.sv | 182 ++++++++++++++++++
 tb/tb_raster_issuer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/raster_issuer.sv
// raster_issuer
//   Source side of the addressed-pixel stream that feeds the render pipeline
//   ahead of the line aligner. The block walks the screen in raster order and
//   issues one (x, y, addr) request for each accepted handshake. A line starts
//   only when the downstream line buffer has returned a line credit.
//
// Ports
//   PPL_clk      pipeline clock, all logic on the rising edge
//   rst_n        asynchronous reset, active low
//   frame_start  one-cycle pulse that arms one frame (ignored unless idle)
//   line_done    one-cycle pulse; downstream freed one line (returns a credit)
//   pix_ready    pipeline accepts the request this cycle
//   pix_valid    request valid
//   pix_x/pix_y  column / row of the current request
//   pix_addr     linear address pix_y*H_DISP + pix_x
//   pix_last     high with the request for the final pixel of the frame
//   busy         high whenever the issuer is not idle
//   frame_done   one-cycle pulse after the last pixel is accepted
//   credit_err   sticky credit-overflow flag, cleared only by reset

module raster_issuer #(
  parameter int H_DISP       = 1280,
  parameter int V_DISP       = 720,
  parameter int LINE_CREDITS = 1,
  parameter int ADDR_W       = 20,
  localparam int X_W = (H_DISP > 1) ? $clog2(H_DISP) : 1,
  localparam int Y_W = (V_DISP > 1) ? $clog2(V_DISP) : 1,
  localparam int C_W = $clog2(LINE_CREDITS + 1)
) (
  input  logic              PPL_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              line_done,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_last,
  output logic              busy,
  output logic              frame_done,
  output logic              credit_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [C_W-1:0]      credit_q, credit_d;

  logic take;
  logic xfer;
  logic x_end;
  logic y_end;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    err_d    = err_q;
    credit_d = credit_q;

    // A credit is consumed exactly on the WAIT->ISSUE transition.
    take  = (state_q == S_WAIT) && (credit_q != '0);
    xfer  = valid_q && pix_ready;
    x_end = (x_q == X_W'(H_DISP - 1));
    y_end = (y_q == Y_W'(V_DISP - 1));

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_WAIT;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end
      end
      S_WAIT: begin
        if (take) begin
          state_d = S_ISSUE;
          valid_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (xfer) begin
          if (x_end) begin
            valid_d = 1'b0;
            if (y_end) begin
              // Coordinates hold through DONE and are cleared on the way out.
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_WAIT;
              x_d     = '0;
              y_d     = y_q + Y_W'(1);
              addr_d  = addr_q + ADDR_W'(1);
            end
          end else begin
            x_d    = x_q + X_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Credit return and take in the same cycle cancel out. A return with
    // the counter already full and no take is an overflow: saturate, flag.
    if (line_done && !take) begin
      if (credit_q == C_W'(LINE_CREDITS)) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + C_W'(1);
      end
    end else if (take && !line_done) begin
      credit_d = credit_q - C_W'(1);
    end

    last_d = valid_d && (x_d == X_W'(H_DISP - 1)) && (y_d == Y_W'(V_DISP - 1));
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge PPL_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      credit_q <= C_W'(LINE_CREDITS);
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      credit_q <= credit_d;
    end
  end

  assign pix_valid  = valid_q;
  assign pix_x      = x_q;
  assign pix_y      = y_q;
  assign pix_addr   = addr_q;
  assign pix_last   = last_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_raster_issuer.sv
// Bench for raster_issuer on a 4x2 screen with one line credit. The reference
// model tracks the frame as a single pixel index plus a credit count; the
// expected coordinates are derived from that index arithmetically.

module tb_raster_issuer;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int LC = 1;
  localparam int AW = 20;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_ISSUE = 2;
  localparam int M_DONE  = 3;

  logic          clk;
  logic          rst_n;
  logic          frame_start;
  logic          line_done;
  logic          pix_ready;
  logic          pix_valid;
  logic [1:0]    pix_x;
  logic [0:0]    pix_y;
  logic [AW-1:0] pix_addr;
  logic          pix_last;
  logic          busy;
  logic          frame_done;
  logic          credit_err;

  int checks   = 0;
  int failures = 0;

  // reference model
  int m_mode = M_IDLE;
  int m_n    = 0;
  int m_cred = LC;
  int m_err  = 0;

  int fd_cnt   = 0;
  int xfer_cnt = 0;

  raster_issuer #(
    .H_DISP(H), .V_DISP(V), .LINE_CREDITS(LC), .ADDR_W(AW)
  ) dut (
    .PPL_clk(clk), .rst_n(rst_n), .frame_start(frame_start), .line_done(line_done),
    .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_addr(pix_addr), .pix_last(pix_last), .busy(busy), .frame_done(frame_done),
    .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_n    = 0;
    m_cred = LC;
    m_err  = 0;
  endtask

  task automatic model_edge(input logic fs, input logic ld, input logic rdy);
    bit take;
    take = (m_mode == M_WAIT) && (m_cred > 0);
    case (m_mode)
      M_IDLE:  if (fs) begin m_mode = M_WAIT; m_n = 0; end
      M_WAIT:  if (take) m_mode = M_ISSUE;
      M_ISSUE: if (rdy) begin
        if (m_n == H * V - 1) m_mode = M_DONE;
        else begin
          if (m_n % H == H - 1) m_mode = M_WAIT;
          m_n++;
        end
      end
      default: begin m_mode = M_IDLE; m_n = 0; end
    endcase
    m_cred = m_cred + int'(ld) - int'(take);
    if (m_cred > LC) begin
      m_cred = LC;
      m_err  = 1;
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (m_mode == M_ISSUE);
    chk("pix_valid",  32'(pix_valid),  32'(v));
    chk("pix_x",      32'(pix_x),      32'(m_n % H));
    chk("pix_y",      32'(pix_y),      32'(m_n / H));
    chk("pix_addr",   32'(pix_addr),   32'(m_n));
    chk("pix_last",   32'(pix_last),   32'(v && (m_n == H * V - 1)));
    chk("busy",       32'(busy),       32'(m_mode != M_IDLE));
    chk("frame_done", 32'(frame_done), 32'(m_mode == M_DONE));
    chk("credit_err", 32'(credit_err), 32'(m_err));
    if (frame_done) fd_cnt++;
  endtask

  task automatic step(input logic fs, input logic ld, input logic rdy);
    frame_start = fs;
    line_done   = ld;
    pix_ready   = rdy;
    if (pix_valid && rdy) xfer_cnt++;
    @(posedge clk);
    model_edge(fs, ld, rdy);
    #1;
    compare_all();
    frame_start = 1'b0;
    line_done   = 1'b0;
  endtask

  // line_done timed to the transfer that finishes a line
  function automatic logic line_end_xfer(input logic rdy);
    return (m_mode == M_ISSUE) && (m_n % H == H - 1) && rdy;
  endfunction

  initial begin
    logic rdy;
    logic ld;
    logic fs;
    bit   found;
    logic [3:0] pat;

    rst_n       = 1'b0;
    frame_start = 1'b0;
    line_done   = 1'b0;
    pix_ready   = 1'b0;
    #3;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    compare_all();
    rst_n = 1'b1;

    // 1: full frame, credit returned after every line
    fd_cnt = 0; xfer_cnt = 0;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, line_end_xfer(1'b1), 1'b1);
    chk("t1_xfers", 32'(xfer_cnt), 32'd8);
    chk("t1_frame_done_pulses", 32'(fd_cnt), 32'd1);

    // 2: no credit return -> only line 0 issues, then one line_done resumes
    xfer_cnt = 0;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    chk("t2_stalled_xfers", 32'(xfer_cnt), 32'd4);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1);
    chk("t2_total_xfers", 32'(xfer_cnt), 32'd8);
    step(1'b0, 1'b1, 1'b0);

    // 3: ready pattern 1,0,0,1 during issue
    xfer_cnt = 0;
    pat = 4'b1001;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      rdy = pat[3 - (i % 4)];
      step(1'b0, line_end_xfer(rdy), rdy);
    end
    chk("t3_xfers", 32'(xfer_cnt), 32'd8);

    // 4: line_done coincides with the credit take
    xfer_cnt = 0;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
    chk("t4_xfers", 32'(xfer_cnt), 32'd8);
    step(1'b0, 1'b1, 1'b0);

    // 5: overflow with credit full -> sticky error, counter saturated
    step(1'b0, 1'b1, 1'b0);
    chk("t5_err_set", 32'(credit_err), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
    chk("t5_err_sticky", 32'(credit_err), 32'd1);
    xfer_cnt = 0;
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    chk("t5_saturated_xfers", 32'(xfer_cnt), 32'd4);

    // 6: asynchronous reset while pixel 5 is offered
    step(1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1);
      found = pix_valid && (pix_addr == AW'(5));
    end
    chk("t6_reach_addr5", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk); #1;
    compare_all();
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("t6_restart_addr", 32'(pix_addr), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);

    // random traffic, three rounds separated by resets
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 600; i++) begin
        fs  = ($urandom_range(0, 7) == 0);
        rdy = ($urandom_range(0, 2) != 0);
        ld  = ((m_cred < LC) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 60) == 0);
        step(fs, ld, rdy);
      end
      rst_n = 1'b0;
      #2;
      model_reset();
      compare_all();
      @(posedge clk); #1;
      rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
